shaper_event_ctrl: RTL and testbench

- Sequencing controller for the trapezoidal shaping filter.
- Owns the filter's active-low reset and gates the filter output until the pipeline has settled.
- Detects threshold crossings on the shaped signal, finds the peak amplitude and the peak timestamp, and delivers one event record per pulse over a valid/ready handshake.
- Sits between the filter output and the readout FIFO; also counts pulses lost to dead time.

---
 rtl/shaper_event_ctrl.sv | 149 ++++++++++++++
 tb/tb_shaper_event_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/shaper_event_ctrl.sv
// rtl/shaper_event_ctrl.sv - trapezoidal shaper sequencing, peak capture and event delivery
// Owns the filter reset, masks settling, and reports one peak record per pulse.
module shaper_event_ctrl #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int TS_WIDTH         = 32,
  parameter int SETTLE_CYCLES    = 32,
  parameter int MAX_WIDTH        = 64,
  parameter int HOLDOFF_CYCLES   = 20,
  parameter int LOST_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        enable,
  input  logic [SIZE_FILTER_DATA-1:0] threshold,
  input  logic [SIZE_FILTER_DATA-1:0] filter_data,
  output logic                        filter_reset_n,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [SIZE_FILTER_DATA-1:0] evt_amplitude,
  output logic [TS_WIDTH-1:0]         evt_timestamp,
  output logic                        evt_pileup,
  output logic [LOST_WIDTH-1:0]       lost_count,
  output logic                        busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + MAX_WIDTH + HOLDOFF_CYCLES + 1);

  typedef enum logic [2:0] {
    S_CLEAR, S_SETTLE, S_ARMED, S_PEAK, S_REPORT, S_HOLDOFF
  } state_t;

  state_t                      state, state_next;
  logic [CNT_W-1:0]            phase, phase_next;
  logic [TS_WIDTH-1:0]         ts;
  logic [SIZE_FILTER_DATA-1:0] peak_amp;
  logic [TS_WIDTH-1:0]         peak_ts;
  logic                        prev_above;
  logic                        above, trig, upd;
  logic                        load_evt, pileup_next;
  logic [SIZE_FILTER_DATA-1:0] amp_new;
  logic [TS_WIDTH-1:0]         ts_new;

  assign above   = $signed(filter_data) > $signed(threshold);
  assign trig    = enable && above && !prev_above;
  // strict compare keeps the first sample of a flat top
  assign upd     = $signed(filter_data) > $signed(peak_amp);
  assign amp_new = upd ? filter_data : peak_amp;
  assign ts_new  = upd ? ts : peak_ts;
  assign busy    = (state != S_ARMED);

  always_comb begin
    state_next  = state;
    phase_next  = phase + 1'b1;
    load_evt    = 1'b0;
    pileup_next = 1'b0;
    case (state)
      S_CLEAR: begin
        if (phase == CNT_W'(1)) begin
          state_next = S_SETTLE;
          phase_next = '0;
        end
      end
      S_SETTLE: begin
        if (phase == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_next = S_ARMED;
          phase_next = '0;
        end
      end
      S_ARMED: begin
        phase_next = '0;
        if (trig) begin
          state_next = S_PEAK;
          phase_next = CNT_W'(1);
        end
      end
      S_PEAK: begin
        // phase holds samples already taken; the current one is phase+1
        if (!above) begin
          state_next = S_REPORT;
          load_evt   = 1'b1;
        end else if (phase == CNT_W'(MAX_WIDTH - 1)) begin
          state_next  = S_REPORT;
          load_evt    = 1'b1;
          pileup_next = 1'b1;
        end
      end
      S_REPORT: begin
        phase_next = '0;
        if (evt_ready) state_next = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (phase == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          state_next = S_ARMED;
          phase_next = '0;
        end
      end
      default: begin
        state_next = S_CLEAR;
        phase_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state          <= S_CLEAR;
      phase          <= '0;
      ts             <= '0;
      lost_count     <= '0;
      evt_valid      <= 1'b0;
      evt_amplitude  <= '0;
      evt_timestamp  <= '0;
      evt_pileup     <= 1'b0;
      filter_reset_n <= 1'b0;
      prev_above     <= 1'b0;
      peak_amp       <= '0;
      peak_ts        <= '0;
    end else begin
      state          <= state_next;
      phase          <= phase_next;
      ts             <= ts + 1'b1;
      filter_reset_n <= (state_next != S_CLEAR);
      prev_above     <= (state == S_CLEAR || state == S_SETTLE) ? 1'b0 : above;

      if (state == S_ARMED && trig) begin
        peak_amp <= filter_data;
        peak_ts  <= ts;
      end else if (state == S_PEAK && upd) begin
        peak_amp <= filter_data;
        peak_ts  <= ts;
      end

      if (load_evt) begin
        evt_valid     <= 1'b1;
        evt_amplitude <= amp_new;
        evt_timestamp <= ts_new;
        evt_pileup    <= pileup_next;
      end else if (state == S_REPORT && evt_ready) begin
        evt_valid <= 1'b0;
      end

      if ((state == S_REPORT || state == S_HOLDOFF) && trig &&
          lost_count != {LOST_WIDTH{1'b1}})
        lost_count <= lost_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_shaper_event_ctrl.sv
// tb/tb_shaper_event_ctrl.sv - scoreboard bench for shaper_event_ctrl
module tb_shaper_event_ctrl;

  logic        clk = 1'b0;
  logic        reset, clear, enable, evt_ready;
  logic [15:0] threshold, filter_data;
  logic        filter_reset_n, evt_valid, evt_pileup, busy;
  logic [15:0] evt_amplitude, lost_count;
  logic [31:0] evt_timestamp;

  logic        s_reset, s_ready, s_fr_n, s_valid, s_pile, s_busy;
  logic [15:0] s_data, s_amp;
  logic [31:0] s_ts;
  logic [3:0]  s_lost;

  logic [31:0] tb_ts;
  int          n_checks = 0;
  int          n_errors = 0;

  typedef struct {
    logic [15:0] amp;
    logic [31:0] ts;
    logic        pile;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  shaper_event_ctrl dut (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable),
    .threshold(threshold), .filter_data(filter_data),
    .filter_reset_n(filter_reset_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_amplitude(evt_amplitude), .evt_timestamp(evt_timestamp),
    .evt_pileup(evt_pileup), .lost_count(lost_count), .busy(busy)
  );

  // narrow loss counter so saturation is reachable in a short run
  shaper_event_ctrl #(.LOST_WIDTH(4)) u_sat (
    .clk(clk), .reset(s_reset), .clear(1'b0), .enable(1'b1),
    .threshold(16'd100), .filter_data(s_data),
    .filter_reset_n(s_fr_n), .evt_valid(s_valid), .evt_ready(s_ready),
    .evt_amplitude(s_amp), .evt_timestamp(s_ts),
    .evt_pileup(s_pile), .lost_count(s_lost), .busy(s_busy)
  );

  always @(posedge clk) tb_ts <= (reset || clear) ? 32'd0 : tb_ts + 32'd1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] amp, input logic [31:0] ts, input logic pile);
    exp_t e;
    e.amp = amp; e.ts = ts; e.pile = pile;
    exp_q.push_back(e);
  endtask

  // k counts edges after the reset/clear edge; above-threshold data during settle is ignored
  task automatic settle_check();
    for (int k = 0; k <= 36; k++) begin
      check("settle_frn", filter_reset_n, (k >= 2));
      check("settle_busy", busy, (k < 34));
      filter_data = (k >= 5 && k < 9) ? 16'd300 : 16'd0;
      tick();
    end
    check("settle_novalid", evt_valid, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!reset && !clear && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_evt", evt_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("evt_amp", evt_amplitude, e.amp);
        check("evt_ts", evt_timestamp, e.ts);
        check("evt_pile", evt_pileup, e.pile);
      end
    end
  end

  initial begin
    int guard;
    logic [31:0] t;
    reset = 1'b1; clear = 1'b0; enable = 1'b1; evt_ready = 1'b1;
    threshold = 16'd100; filter_data = 16'd0;
    s_reset = 1'b1; s_ready = 1'b0; s_data = 16'd0;

    // startup
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_frn", filter_reset_n, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_valid", evt_valid, 1'b0);
      check("rst_evt", {evt_pileup, evt_amplitude, evt_timestamp}, 64'd0);
      check("rst_lost", lost_count, 16'd0);
    end
    reset = 1'b0;
    settle_check();

    // single pulse with the 150 sample at ts=1000
    guard = 0;
    while (tb_ts != 32'd999 && guard < 2000) begin tick(); guard++; end
    check("ts_reach", tb_ts, 32'd999);
    push(16'd420, 32'd1002, 1'b0);
    filter_data = 16'd50;  tick();
    filter_data = 16'd150; tick();
    filter_data = 16'd300; tick();
    filter_data = 16'd420; tick();
    filter_data = 16'd420; tick();
    filter_data = 16'd380; tick();
    filter_data = 16'd90;
    check("pulse_pre_valid", evt_valid, 1'b0);
    tick();
    check("pulse_latency", evt_valid, 1'b1);
    filter_data = 16'd0;
    for (int i = 0; i < 25; i++) tick();

    // backpressure with a second pulse lost during REPORT
    evt_ready = 1'b0;
    filter_data = 16'd200; tick();
    t = tb_ts;
    filter_data = 16'd250; tick();
    filter_data = 16'd0;   tick();
    push(16'd250, t, 1'b0);
    guard = 0;
    while (!evt_valid && guard < 10) begin tick(); guard++; end
    for (int i = 0; i < 50; i++) begin
      check("bp_hold", {evt_valid, evt_pileup, evt_amplitude, evt_timestamp},
            {1'b1, 1'b0, 16'd250, t});
      filter_data = (i == 10) ? 16'd300 : 16'd0;
      tick();
    end
    check("bp_lost", lost_count, 16'd1);
    evt_ready = 1'b1;
    for (int i = 0; i < 25; i++) tick();

    // pileup at MAX_WIDTH, then no retrigger while the level stays high
    push(16'd500, tb_ts, 1'b1);
    filter_data = 16'd500; tick();
    for (int n = 2; n <= 64; n++) begin
      tick();
      if (n == 63) check("pile_early", evt_valid, 1'b0);
      if (n == 64) check("pile_latency", evt_valid, 1'b1);
    end
    for (int i = 0; i < 50; i++) tick();
    check("pile_no_retrig", busy, 1'b0);
    filter_data = 16'd100;
    for (int i = 0; i < 3; i++) tick();
    check("thr_equal", busy, 1'b0);
    push(16'd500, tb_ts, 1'b0);
    filter_data = 16'd500; tick();
    filter_data = 16'd0;   tick();
    for (int i = 0; i < 25; i++) tick();
    check("pile_lost", lost_count, 16'd1);

    // clear during PEAK
    filter_data = 16'd300; tick();
    filter_data = 16'd350; tick();
    check("clr_peak_busy", busy, 1'b1);
    clear = 1'b1; filter_data = 16'd0; tick();
    clear = 1'b0;
    check("clr_lost", lost_count, 16'd0);
    settle_check();

    // clear during REPORT with backpressure
    evt_ready = 1'b0;
    filter_data = 16'd300; tick();
    filter_data = 16'd0;   tick();
    check("clr_rep_valid", evt_valid, 1'b1);
    clear = 1'b1; tick();
    clear = 1'b0; evt_ready = 1'b1;
    check("clr_rep_drop", evt_valid, 1'b0);
    settle_check();
    push(16'd300, tb_ts, 1'b0);
    filter_data = 16'd300; tick();
    filter_data = 16'd0;   tick();
    for (int i = 0; i < 25; i++) tick();
    check("clr_lost_after", lost_count, 16'd0);

    // signed threshold
    threshold = -16'sd50; filter_data = -16'sd80;
    tick(); tick();
    check("neg_no_trig", busy, 1'b0);
    push(-16'sd20, tb_ts, 1'b0);
    filter_data = -16'sd20; tick();
    filter_data = -16'sd80; tick();
    for (int i = 0; i < 25; i++) tick();

    // loss counter saturation on the narrow instance
    tick(); s_reset = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    s_data = 16'd300; tick();
    s_data = 16'd0;   tick();
    check("sat_valid", s_valid, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      s_data = 16'd300; tick();
      s_data = 16'd0;   tick();
      if (i == 5) check("sat_count5", s_lost, 4'd5);
    end
    check("sat_max", s_lost, 4'hF);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
